tl_mem_responder: RTL and testbench
===================================

Name: tl_mem_responder

Overview:
- TileLink-UL responder (slave) that serves the A-channel Get / PutFullData / PutPartialData requests issued by the data and instruction caches.
- Returns AccessAck or AccessAckData on the D channel.
- Backed by an internal 64-bit-wide word RAM with a programmable access latency.
- Single outstanding transaction; this is the memory-side end of the path whose AccessAckData fills cache lines.

Parameters:
- BASE_ADDR, 64'h8000_0000, first byte address served.
- DEPTH, 512, number of 64-bit words (power of 2).
- LATENCY, 2, cycles from A acceptance to d_valid (allowed range 1..15).
- SRC_W, 4, width of the source ID fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  A-channel request valid
- a_ready  out  1  responder can accept A
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- a_size  in  3  log2 bytes (0..3)
- a_mask  in  8  byte lane enables
- a_address  in  64  byte address
- a_data  in  64  write data, lane-aligned
- a_source  in  SRC_W  requester ID
- d_valid  out  1  response valid
- d_ready  in  1  requester accepts D
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_size  out  3  echo of a_size
- d_source  out  SRC_W  echo of a_source
- d_data  out  64  full aligned word for Get, else 0
- d_error  out  1  request was rejected

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: state=IDLE, a_ready=0 during rst and 1 the first cycle after, d_valid=0, d_opcode=0, d_size=0, d_source=0, d_data=0, d_error=0, latency counter=0.
- Reset mid-transaction: aborts the transaction with no D beat. A pending write that has not committed is dropped. RAM contents are NOT cleared by reset.
- FSM state IDLE: a_ready=1. On a_valid&a_ready, latch opcode/size/mask/address/data/source, set counter=LATENCY-1, go to WAIT.
- FSM state WAIT: a_ready=0. Counter decrements each cycle. When counter==0, perform the access in that same cycle and go to RESP.
  - Write: RAM[idx] bytes with mask bit set are replaced.
  - Read: word is registered into d_data.
  - With LATENCY=1, WAIT lasts exactly one cycle, so d_valid rises two cycles after the accept edge... normative: d_valid asserts LATENCY+1 cycles after the accepting edge.
- FSM state RESP: d_valid=1 and all d_* fields held stable until d_valid&d_ready. On that handshake: d_valid=0, go to IDLE, a_ready=1 on the next cycle.
  - No A acceptance while in WAIT or RESP. Throughput is one transaction per LATENCY+2 cycles minimum.
- Index: idx = (a_address - BASE_ADDR) >> 3, taking log2(DEPTH) bits.
- Error conditions (any one sets d_error=1; there is no RAM write and d_data=0):
  - Address below BASE_ADDR, or at/above BASE_ADDR+8*DEPTH.
  - Address not aligned to 2^a_size.
  - a_size > 3.
  - Unsupported opcode (2, 3, 5, 6, 7).
  - PutFullData whose a_mask differs from the size-derived mask shifted by address[2:0].
- Size-derived mask: size 0 gives 8'h01, size 1 gives 8'h03, size 2 gives 8'h0F, size 3 gives 8'hFF. It is shifted left by address[2:0].
- PutPartialData: the written lanes are (a_mask & derived mask). Lanes set in a_mask but outside the derived mask are ignored, not an error.
- Response opcode: Get (including an errored Get) returns AccessAckData (1). Puts return AccessAck (0) with d_data=0.
- Get data: the full 64-bit word, unshifted and unmasked. The requester extracts bytes by offset.
- d_size and d_source echo the latched request.
- Read-after-write: a Get accepted after a Put's D handshake observes the written data.

Test Plan:
- Write then read: reset, PutFullData size 3 @BASE_ADDR+8, data 64'h1122334455667788, mask FF -> AccessAck, d_error=0. Then Get size 3 same address -> opcode 1, d_data=64'h1122334455667788, d_valid exactly LATENCY+1 cycles after accept.
- Partial write: PutPartialData size 0 @BASE_ADDR+0xB, mask 8'h08, a_data byte3=8'hAB over a word of all 0 -> Get @BASE_ADDR+8 returns 64'h00000000AB000000.
- Errors:
  - Get @BASE_ADDR-8 -> AccessAckData, d_error=1, d_data=0.
  - Get size 2 @BASE_ADDR+2 (misaligned) -> d_error=1.
  - PutFullData size 1 @BASE_ADDR with mask 8'h01 -> AccessAck with d_error=1, RAM unchanged.
- Backpressure: hold d_ready=0 for 10 cycles -> d_valid and all d_* stable, a_ready=0 throughout. Raise d_ready -> one handshake, a_ready=1 next cycle.
- Reset mid-op: assert rst during WAIT of a Put -> no D beat, a_ready=0 while rst is high and 1 after it drops. A later Get of that word returns its prior value.
- Source echo and boundary: Get with a_source=4'hA @BASE_ADDR+8*(DEPTH-1) -> d_source=4'hA, d_error=0. Same request @BASE_ADDR+8*DEPTH -> d_error=1.

Source files
------------

// File: rtl/tl_mem_responder.sv
// TileLink-UL memory responder: serves Get/PutFullData/PutPartialData from an
// internal 64-bit word RAM, one transaction at a time, with a fixed access latency.
module tl_mem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          DEPTH     = 512,
  parameter int          LATENCY   = 2,
  parameter int          SRC_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_opcode,
  input  logic [2:0]       a_size,
  input  logic [7:0]       a_mask,
  input  logic [63:0]      a_address,
  input  logic [63:0]      a_data,
  input  logic [SRC_W-1:0] a_source,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [2:0]       d_opcode,
  output logic [2:0]       d_size,
  output logic [SRC_W-1:0] d_source,
  output logic [63:0]      d_data,
  output logic             d_error
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q;

  logic [2:0]       req_opcode;
  logic [2:0]       req_size;
  logic [7:0]       req_mask;
  logic [63:0]      req_addr;
  logic [63:0]      req_data;
  logic [SRC_W-1:0] req_source;

  logic [63:0] mem [DEPTH];

  logic          accept, access, do_write;
  logic [63:0]   off;
  logic [AW-1:0] idx;
  logic [7:0]    size_mask, lane_mask, wr_mask;
  logic          is_get, is_put_full, is_put_part, misaligned, req_err;

  assign a_ready = (state_q == IDLE) && !rst;
  assign accept  = a_valid && a_ready;
  assign access  = (state_q == WAIT) && (cnt_q == 4'd0);
  assign d_valid = (state_q == RESP);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (d_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request decode works on the latched fields so the A inputs are free after accept.
  always_comb begin
    off = req_addr - BASE_ADDR;
    idx = off[AW+2:3];
    case (req_size[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    lane_mask = size_mask << req_addr[2:0];
    case (req_size)
      3'd1:    misaligned = req_addr[0];
      3'd2:    misaligned = |req_addr[1:0];
      3'd3:    misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    is_get      = (req_opcode == 3'd4);
    is_put_full = (req_opcode == 3'd0);
    is_put_part = (req_opcode == 3'd1);
    // Below-base addresses wrap to huge offsets, so one compare covers both ends.
    req_err = (off >= SPAN) || misaligned || (req_size > 3'd3)
           || !(is_get || is_put_full || is_put_part)
           || (is_put_full && (req_mask != lane_mask));
    wr_mask  = req_mask & lane_mask;
    do_write = access && !rst && !req_err && !is_get;
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) mem[idx][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 4'd0;
      req_opcode <= 3'd0;
      req_size   <= 3'd0;
      req_mask   <= 8'd0;
      req_addr   <= 64'd0;
      req_data   <= 64'd0;
      req_source <= '0;
      d_opcode   <= 3'd0;
      d_size     <= 3'd0;
      d_source   <= '0;
      d_data     <= 64'd0;
      d_error    <= 1'b0;
    end else begin
      if (accept) begin
        req_opcode <= a_opcode;
        req_size   <= a_size;
        req_mask   <= a_mask;
        req_addr   <= a_address;
        req_data   <= a_data;
        req_source <= a_source;
        cnt_q      <= CNT_INIT;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access) begin
        d_opcode <= {2'b00, is_get};
        d_size   <= req_size;
        d_source <= req_source;
        d_error  <= req_err;
        d_data   <= (is_get && !req_err) ? mem[idx] : 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_tl_mem_responder.sv
// Randomized self-checking bench for tl_mem_responder against a byte-level memory model.
module tb_tl_mem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 512;
  localparam int          LAT   = 2;
  localparam int          SRC_W = 4;

  logic clk, rst;
  logic a_valid, a_ready, d_valid, d_ready, d_error;
  logic [2:0] a_opcode, a_size, d_opcode, d_size;
  logic [7:0] a_mask;
  logic [63:0] a_address, a_data, d_data;
  logic [SRC_W-1:0] a_source, d_source;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mbytes [DEPTH*8];

  tl_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT), .SRC_W(SRC_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_mask(a_mask), .a_address(a_address), .a_data(a_data), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_data(d_data), .d_error(d_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, got no finish, required finish");
    $fatal(1);
  end

  // Reference: memory as a flat byte array; rules applied directly.
  function automatic void model(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] mask,
                                input logic [63:0] addr, input logic [63:0] data,
                                output logic err, output logic [2:0] rop, output logic [63:0] rdata);
    logic [63:0] o;
    logic [8:0]  t9;
    logic [7:0]  der;
    int nb, bb;
    err = 1'b0;
    rdata = 64'd0;
    rop = (op == 3'd4) ? 3'd1 : 3'd0;
    if (addr < BASE || addr >= BASE + 64'(DEPTH) * 64'd8) err = 1'b1;
    if (sz > 3'd3) err = 1'b1;
    nb = 1 << sz[1:0];
    if ((addr % 64'(nb)) != 64'd0) err = 1'b1;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) err = 1'b1;
    t9 = (9'd1 << nb) - 9'd1;
    der = t9[7:0] << addr[2:0];
    if (op == 3'd0 && mask != der) err = 1'b1;
    if (!err) begin
      o = addr - BASE;
      bb = int'(o[63:3]) * 8;
      for (int b = 0; b < 8; b++) begin
        if (op == 3'd4) rdata[8*b +: 8] = mbytes[bb + b];
        else if (mask[b] && der[b]) mbytes[bb + b] = data[8*b +: 8];
      end
    end
  endfunction

  // Drives one request, returns the first D beat and its latency counted from the accept cycle.
  task automatic xact(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] mask,
                      input logic [63:0] addr, input logic [63:0] data, input logic [3:0] src,
                      input int hold,
                      output logic [2:0] r_op, output logic [2:0] r_sz, output logic [3:0] r_src,
                      output logic [63:0] r_data, output logic r_err, output int lat);
    int n;
    n = 0;
    while (!a_ready && n < 50) begin @(posedge clk); #1; n++; end
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_mask = mask;
    a_address = addr; a_data = data; a_source = src;
    @(posedge clk); #1;
    a_valid = 1'b0;
    lat = 1;
    while (!d_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!d_valid) lat = -1;
    r_op = d_opcode; r_sz = d_size; r_src = d_source; r_data = d_data; r_err = d_error;
    if (d_valid) begin
      repeat (hold) begin @(posedge clk); #1; end
      d_ready = 1'b1;
      @(posedge clk); #1;
      d_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL rst_a_ready: got %b expected 0", a_ready); end
    n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rst_d_valid: got %b expected 0", d_valid); end
    n_vec++; if ({d_opcode, d_size, d_source, d_error} !== 11'd0) begin n_err++;
      $display("FAIL rst_d_fields: got op=%0d sz=%0d src=%0d err=%b expected all 0", d_opcode, d_size, d_source, d_error); end
    n_vec++; if (d_data !== 64'd0) begin n_err++; $display("FAIL rst_d_data: got %h expected 0", d_data); end
    rst = 1'b0;
    #1;
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_a_ready: got %b expected 1", a_ready); end
  endtask

  task automatic init_ram();
    logic [2:0] r_op, r_sz; logic [3:0] r_src; logic [63:0] r_data, wd, ed; logic r_err, e_err; logic [2:0] e_op;
    int lat;
    for (int i = 0; i < DEPTH; i++) begin
      wd = {$urandom, $urandom};
      model(3'd0, 3'd3, 8'hFF, BASE + 64'(8*i), wd, e_err, e_op, ed);
      xact(3'd0, 3'd3, 8'hFF, BASE + 64'(8*i), wd, 4'd0, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    end
  endtask

  task automatic test_write_read();
    logic [2:0] r_op, r_sz; logic [3:0] r_src; logic [63:0] r_data, ed; logic r_err, e_err; logic [2:0] e_op;
    int lat;
    model(3'd0, 3'd3, 8'hFF, BASE + 64'd8, 64'h1122334455667788, e_err, e_op, ed);
    xact(3'd0, 3'd3, 8'hFF, BASE + 64'd8, 64'h1122334455667788, 4'd3, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_op !== 3'd0) begin n_err++; $display("FAIL wr_opcode: got %0d expected 0", r_op); end
    n_vec++; if (r_err !== 1'b0) begin n_err++; $display("FAIL wr_error: got %b expected 0", r_err); end
    n_vec++; if (r_data !== 64'd0) begin n_err++; $display("FAIL wr_data: got %h expected 0", r_data); end
    n_vec++; if (lat != LAT + 1) begin n_err++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT + 1); end
    xact(3'd4, 3'd3, 8'hFF, BASE + 64'd8, 64'd0, 4'd5, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_op !== 3'd1) begin n_err++; $display("FAIL rd_opcode: got %0d expected 1", r_op); end
    n_vec++; if (r_data !== 64'h1122334455667788) begin n_err++; $display("FAIL rd_data: got %h expected 1122334455667788", r_data); end
    n_vec++; if (lat != LAT + 1) begin n_err++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT + 1); end
    n_vec++; if (r_sz !== 3'd3 || r_src !== 4'd5) begin n_err++; $display("FAIL rd_echo: got sz=%0d src=%0d expected sz=3 src=5", r_sz, r_src); end
  endtask

  task automatic test_partial();
    logic [2:0] r_op, r_sz; logic [3:0] r_src; logic [63:0] r_data, ed, junk; logic r_err, e_err; logic [2:0] e_op;
    int lat;
    model(3'd0, 3'd3, 8'hFF, BASE + 64'd8, 64'd0, e_err, e_op, ed);
    xact(3'd0, 3'd3, 8'hFF, BASE + 64'd8, 64'd0, 4'd0, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    junk = {$urandom, $urandom};
    junk[31:24] = 8'hAB;
    model(3'd1, 3'd0, 8'h08, BASE + 64'hB, junk, e_err, e_op, ed);
    xact(3'd1, 3'd0, 8'h08, BASE + 64'hB, junk, 4'd1, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_err !== 1'b0 || r_op !== 3'd0) begin n_err++; $display("FAIL part_ack: got op=%0d err=%b expected op=0 err=0", r_op, r_err); end
    model(3'd4, 3'd3, 8'hFF, BASE + 64'd8, 64'd0, e_err, e_op, ed);
    xact(3'd4, 3'd3, 8'hFF, BASE + 64'd8, 64'd0, 4'd2, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_data !== 64'h00000000AB000000) begin n_err++; $display("FAIL part_readback: got %h expected 00000000ab000000", r_data); end
    n_vec++; if (r_data !== ed) begin n_err++; $display("FAIL part_model: got %h expected %h", r_data, ed); end
  endtask

  task automatic test_errors();
    logic [2:0] r_op, r_sz; logic [3:0] r_src; logic [63:0] r_data, ed; logic r_err, e_err; logic [2:0] e_op;
    int lat;
    xact(3'd4, 3'd3, 8'hFF, BASE - 64'd8, 64'd0, 4'd0, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_op !== 3'd1 || r_err !== 1'b1 || r_data !== 64'd0) begin n_err++;
      $display("FAIL err_below_base: got op=%0d err=%b data=%h expected op=1 err=1 data=0", r_op, r_err, r_data); end
    xact(3'd4, 3'd2, 8'h0F, BASE + 64'd2, 64'd0, 4'd0, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_err !== 1'b1 || r_data !== 64'd0) begin n_err++;
      $display("FAIL err_misaligned: got err=%b data=%h expected err=1 data=0", r_err, r_data); end
    model(3'd0, 3'd1, 8'h01, BASE, 64'hDEAD_BEEF_0BAD_F00D, e_err, e_op, ed);
    xact(3'd0, 3'd1, 8'h01, BASE, 64'hDEAD_BEEF_0BAD_F00D, 4'd0, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_op !== 3'd0 || r_err !== 1'b1) begin n_err++;
      $display("FAIL err_putfull_mask: got op=%0d err=%b expected op=0 err=1", r_op, r_err); end
    model(3'd4, 3'd3, 8'hFF, BASE, 64'd0, e_err, e_op, ed);
    xact(3'd4, 3'd3, 8'hFF, BASE, 64'd0, 4'd0, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_data !== ed) begin n_err++; $display("FAIL err_ram_unchanged: got %h expected %h", r_data, ed); end
  endtask

  task automatic test_backpressure();
    logic [63:0] ed; logic e_err; logic [2:0] e_op;
    int n;
    model(3'd4, 3'd3, 8'hFF, BASE + 64'd160, 64'd0, e_err, e_op, ed);
    n = 0;
    while (!a_ready && n < 50) begin @(posedge clk); #1; n++; end
    a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd3; a_mask = 8'hFF;
    a_address = BASE + 64'd160; a_data = 64'd0; a_source = 4'h6;
    @(posedge clk); #1;
    a_valid = 1'b0;
    n = 0;
    while (!d_valid && n < 40) begin
      n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL bp_wait_a_ready: got %b expected 0", a_ready); end
      @(posedge clk); #1; n++;
    end
    for (int c = 0; c < 10; c++) begin
      n_vec++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL bp_d_valid c=%0d: got %b expected 1", c, d_valid); end
      n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL bp_a_ready c=%0d: got %b expected 0", c, a_ready); end
      n_vec++; if (d_data !== ed) begin n_err++; $display("FAIL bp_d_data c=%0d: got %h expected %h", c, d_data, ed); end
      n_vec++; if (d_opcode !== 3'd1 || d_error !== 1'b0) begin n_err++;
        $display("FAIL bp_d_op c=%0d: got op=%0d err=%b expected op=1 err=0", c, d_opcode, d_error); end
      n_vec++; if (d_size !== 3'd3 || d_source !== 4'h6) begin n_err++;
        $display("FAIL bp_d_echo c=%0d: got sz=%0d src=%0d expected sz=3 src=6", c, d_size, d_source); end
      @(posedge clk); #1;
    end
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;
    n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_d_valid: got %b expected 0", d_valid); end
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL bp_after_a_ready: got %b expected 1", a_ready); end
  endtask

  task automatic test_reset_midop();
    logic [2:0] r_op, r_sz; logic [3:0] r_src; logic [63:0] r_data, ed; logic r_err, e_err; logic [2:0] e_op;
    int lat, n;
    n = 0;
    while (!a_ready && n < 50) begin @(posedge clk); #1; n++; end
    a_valid = 1'b1; a_opcode = 3'd0; a_size = 3'd3; a_mask = 8'hFF;
    a_address = BASE + 64'd240; a_data = 64'hFFFF_0000_FFFF_0000; a_source = 4'h1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_d_valid c=%0d: got %b expected 0", c, d_valid); end
      n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_a_ready c=%0d: got %b expected 0", c, a_ready); end
    end
    rst = 1'b0;
    #1;
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_release: got %b expected 1", a_ready); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_beat c=%0d: got %b expected 0", c, d_valid); end
    end
    model(3'd4, 3'd3, 8'hFF, BASE + 64'd240, 64'd0, e_err, e_op, ed);
    xact(3'd4, 3'd3, 8'hFF, BASE + 64'd240, 64'd0, 4'd0, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_data !== ed) begin n_err++; $display("FAIL rstmid_old_value: got %h expected %h", r_data, ed); end
  endtask

  task automatic test_source_boundary();
    logic [2:0] r_op, r_sz; logic [3:0] r_src; logic [63:0] r_data, ed; logic r_err, e_err; logic [2:0] e_op;
    int lat;
    model(3'd4, 3'd3, 8'hFF, BASE + 64'(8*(DEPTH-1)), 64'd0, e_err, e_op, ed);
    xact(3'd4, 3'd3, 8'hFF, BASE + 64'(8*(DEPTH-1)), 64'd0, 4'hA, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_src !== 4'hA || r_err !== 1'b0) begin n_err++;
      $display("FAIL top_word: got src=%h err=%b expected src=a err=0", r_src, r_err); end
    n_vec++; if (r_data !== ed) begin n_err++; $display("FAIL top_word_data: got %h expected %h", r_data, ed); end
    xact(3'd4, 3'd3, 8'hFF, BASE + 64'(8*DEPTH), 64'd0, 4'hA, 0, r_op, r_sz, r_src, r_data, r_err, lat);
    n_vec++; if (r_src !== 4'hA || r_err !== 1'b1 || r_data !== 64'd0) begin n_err++;
      $display("FAIL past_end: got src=%h err=%b data=%h expected src=a err=1 data=0", r_src, r_err, r_data); end
  endtask

  task automatic test_random();
    logic [2:0] r_op, r_sz; logic [3:0] r_src; logic [63:0] r_data, ed, addr, wd; logic r_err, e_err; logic [2:0] e_op;
    logic [2:0] op, sz; logic [7:0] mask, der; logic [8:0] t9; logic [3:0] src;
    logic [2:0] bad_ops [5];
    int lat, k, sel, nb, hold;
    bad_ops = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    for (int t = 0; t < 80; t++) begin
      addr = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
      sz = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) sz = 3'($urandom_range(4, 7));
      if ($urandom_range(0, 4) != 0) addr = addr & ~((64'd1 << sz[1:0]) - 64'd1);
      k = $urandom_range(0, 19);
      if (k == 0) addr = BASE - 64'(8 * $urandom_range(1, 4));
      else if (k == 1) addr = BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 4));
      sel = $urandom_range(0, 19);
      op = (sel < 8) ? 3'd4 : (sel < 14) ? 3'd0 : (sel < 18) ? 3'd1 : bad_ops[$urandom_range(0, 4)];
      nb = 1 << sz[1:0];
      t9 = (9'd1 << nb) - 9'd1;
      der = t9[7:0] << addr[2:0];
      mask = 8'($urandom);
      if (op == 3'd0 && $urandom_range(0, 6) != 0) mask = der;
      wd = {$urandom, $urandom};
      src = 4'($urandom);
      hold = $urandom_range(0, 3);
      model(op, sz, mask, addr, wd, e_err, e_op, ed);
      xact(op, sz, mask, addr, wd, src, hold, r_op, r_sz, r_src, r_data, r_err, lat);
      n_vec++; if (lat != LAT + 1) begin n_err++; $display("FAIL rnd_latency t=%0d: got %0d expected %0d", t, lat, LAT + 1); end
      n_vec++; if (r_err !== e_err) begin n_err++;
        $display("FAIL rnd_error t=%0d op=%0d sz=%0d addr=%h mask=%h: got %b expected %b", t, op, sz, addr, mask, r_err, e_err); end
      n_vec++; if (r_data !== ed) begin n_err++; $display("FAIL rnd_data t=%0d addr=%h: got %h expected %h", t, addr, r_data, ed); end
      n_vec++; if (r_sz !== sz || r_src !== src) begin n_err++;
        $display("FAIL rnd_echo t=%0d: got sz=%0d src=%0d expected sz=%0d src=%0d", t, r_sz, r_src, sz, src); end
      if (op == 3'd0 || op == 3'd1 || op == 3'd4) begin
        n_vec++; if (r_op !== e_op) begin n_err++; $display("FAIL rnd_opcode t=%0d: got %0d expected %0d", t, r_op, e_op); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; d_ready = 1'b0;
    a_opcode = 3'd0; a_size = 3'd0; a_mask = 8'd0; a_address = 64'd0; a_data = 64'd0; a_source = '0;
    test_reset();
    init_ram();
    test_write_read();
    test_partial();
    test_errors();
    test_backpressure();
    test_reset_midop();
    test_source_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
